// File: rtl/pingala_pkg.sv
// Pingala Prastara engine shared definitions:
// op codes, FSM state encoding and width helpers.
package pingala_pkg;

    localparam logic [2:0] OP_BINOM  = 3'd0;
    localparam logic [2:0] OP_POPCNT = 3'd1;
    localparam logic [2:0] OP_RANK   = 3'd2;
    localparam logic [2:0] OP_UNRANK = 3'd3;
    localparam logic [2:0] OP_NEXT   = 3'd4;
    localparam logic [2:0] OP_MATRA  = 3'd5;

    typedef enum logic [2:0] {
        ST_BUILD,
        ST_IDLE,
        ST_EXEC_RANK,
        ST_EXEC_UNRANK,
        ST_EXEC_FIB,
        ST_RESP
    } state_e;

    function automatic int nw_of(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pingala_prastara_engine_if.sv
// Request/response bundle of the Pingala Prastara engine.
// master drives requests, slave is the engine.
interface pingala_prastara_engine_if #(
    parameter int N_MAX = 16,
    parameter int CW    = 32
);
    import pingala_pkg::*;

    localparam int NW = nw_of(N_MAX);

    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [NW-1:0]    req_n;
    logic [NW-1:0]    req_k;
    logic [N_MAX-1:0] req_pattern;
    logic [CW-1:0]    req_index;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [N_MAX-1:0] rsp_pattern;
    logic [CW-1:0]    rsp_value;
    logic             rsp_err;

    modport master (
        output req_valid, req_op, req_n, req_k,
        output req_pattern, req_index, rsp_ready,
        input  req_ready, rsp_valid, rsp_pattern,
        input  rsp_value, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_n, req_k,
        input  req_pattern, req_index, rsp_ready,
        output req_ready, rsp_valid, rsp_pattern,
        output rsp_value, rsp_err
    );

endinterface

// File: rtl/pingala_meru_table.sv
// Meru Prastara (Pascal triangle) built one row per cycle after
// reset, with two combinational C(i,r) read ports.
module pingala_meru_table #(
    parameter int N_MAX = 16,
    parameter int CW    = 32,
    parameter int NW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [NW-1:0] rd0_i,
    input  logic [NW-1:0] rd0_r,
    input  logic [NW-1:0] rd1_i,
    input  logic [NW-1:0] rd1_r,
    output logic [CW-1:0] rd0_c,
    output logic [CW-1:0] rd1_c,
    output logic          build_last,
    output logic          table_ready
);

    logic [CW-1:0] tbl_q [0:N_MAX][0:N_MAX];
    logic [CW-1:0] prev [0:N_MAX];
    logic [CW-1:0] line_d [0:N_MAX];
    logic [NW-1:0] row_q, row_d;
    logic [NW-1:0] prev_row;
    logic          ready_q, ready_d;

    assign prev_row = row_q - 1'b1;

    always_comb begin
        row_d   = row_q;
        ready_d = ready_q;
        for (int c = 0; c <= N_MAX; c++) begin
            prev[c] = (row_q == '0) ? '0 : tbl_q[prev_row][c];
        end
        line_d[0] = CW'(1);
        for (int c = 1; c <= N_MAX; c++) begin
            line_d[c] = prev[c-1] + prev[c];
        end
        if (!ready_q) begin
            if (row_q == NW'(N_MAX)) begin
                ready_d = 1'b1;
            end else begin
                row_d = row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            ready_q <= 1'b0;
            for (int r = 0; r <= N_MAX; r++) begin
                for (int c = 0; c <= N_MAX; c++) begin
                    tbl_q[r][c] <= '0;
                end
            end
        end else begin
            row_q   <= row_d;
            ready_q <= ready_d;
            if (!ready_q) begin
                for (int c = 0; c <= N_MAX; c++) begin
                    tbl_q[row_q][c] <= line_d[c];
                end
            end
        end
    end

    // Out-of-triangle reads (row beyond N_MAX, which also covers
    // a wrapped row -1, or r > i) are defined as zero.
    assign rd0_c = (rd0_i > NW'(N_MAX) || rd0_r > rd0_i)
                   ? '0 : tbl_q[rd0_i][rd0_r];
    assign rd1_c = (rd1_i > NW'(N_MAX) || rd1_r > rd1_i)
                   ? '0 : tbl_q[rd1_i][rd1_r];

    assign build_last  = !ready_q && (row_q == NW'(N_MAX));
    assign table_ready = ready_q;

endmodule

// File: rtl/pingala_prastara_engine.sv
// Pingala Prastara combinatorics engine: binomial, popcount,
// rank/unrank/next; MATRA op enabled by PINGALA_MATRA_EN.
module pingala_prastara_engine
    import pingala_pkg::*;
#(
    parameter int N_MAX = 16,
    parameter int CW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pingala_prastara_engine_if.slave bus,
    output logic                     table_ready
);

    localparam int NW = nw_of(N_MAX);

    if (CW < N_MAX + 1) begin : g_cw_chk
        $error("CW must be at least N_MAX+1");
    end

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [NW-1:0]    n_q, n_d, k_q, k_d;
    logic [NW-1:0]    i_q, i_d, r_q, r_d;
    logic [N_MAX-1:0] pat_q, pat_d, opat_q, opat_d;
    logic [CW-1:0]    idx_q, idx_d, acc_q, acc_d;
    logic             nxt_q, nxt_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [CW-1:0]    rsp_value_q, rsp_value_d;
    logic [N_MAX-1:0] rsp_pattern_q, rsp_pattern_d;

    logic [NW-1:0]    rd1_i, rd1_r;
    logic [CW-1:0]    rd0_c, rd1_c;
    logic             build_last;
    logic [N_MAX-1:0] req_pat;
    logic [NW-1:0]    req_pop;
    logic             cur_bit, op_res, req_err;
    logic             k_ops, pop_ops, scan_op;
    logic [CW-1:0]    sum, nidx;
    logic [N_MAX-1:0] npat;

    assign rd1_i = (state_q == ST_IDLE) ? bus.req_n : n_q;
    assign rd1_r = (state_q == ST_IDLE) ? bus.req_k : k_q;

    pingala_meru_table #(
        .N_MAX(N_MAX),
        .CW   (CW),
        .NW   (NW)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd0_i      (i_q),
        .rd0_r      (r_q),
        .rd1_i      (rd1_i),
        .rd1_r      (rd1_r),
        .rd0_c      (rd0_c),
        .rd1_c      (rd1_c),
        .build_last (build_last),
        .table_ready(table_ready)
    );

    always_comb begin
        req_pat = '0;
        req_pop = '0;
        cur_bit = 1'b0;
        for (int j = 0; j < N_MAX; j++) begin
            if (NW'(j) < bus.req_n) begin
                req_pat[j] = bus.req_pattern[j];
                req_pop    = req_pop + NW'(bus.req_pattern[j]);
            end
            if (NW'(j) == i_q) cur_bit = pat_q[j];
        end
    end

`ifdef PINGALA_MATRA_EN
    assign op_res = bus.req_op > OP_MATRA;
`else
    assign op_res = bus.req_op >= OP_MATRA;
`endif

    assign pop_ops = (bus.req_op == OP_RANK) || (bus.req_op == OP_NEXT);
    assign scan_op = pop_ops || (bus.req_op == OP_UNRANK);
    assign k_ops   = scan_op || (bus.req_op == OP_BINOM);
    assign req_err = (bus.req_n > NW'(N_MAX)) || op_res
                   || (k_ops && bus.req_k > bus.req_n)
                   || (pop_ops && req_pop != bus.req_k)
                   || (bus.req_op == OP_UNRANK && bus.req_index >= rd1_c);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        n_d           = n_q;
        k_d           = k_q;
        i_d           = i_q;
        r_d           = r_q;
        pat_d         = pat_q;
        opat_d        = opat_q;
        idx_d         = idx_q;
        acc_d         = acc_q;
        nxt_d         = nxt_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_err_d     = rsp_err_q;
        rsp_value_d   = rsp_value_q;
        rsp_pattern_d = rsp_pattern_q;
        sum           = acc_q;
        nidx          = '0;
        npat          = opat_q;
        unique case (state_q)
            ST_BUILD: begin
                if (build_last) begin
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    req_ready_d   = 1'b0;
                    op_d          = bus.req_op;
                    n_d           = bus.req_n;
                    k_d           = bus.req_k;
                    i_d           = bus.req_n - 1'b1;
                    r_d           = bus.req_k;
                    pat_d         = req_pat;
                    opat_d        = '0;
                    acc_d         = '0;
                    idx_d         = bus.req_index;
                    nxt_d         = (bus.req_op == OP_NEXT);
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b0;
                    rsp_value_d   = '0;
                    rsp_pattern_d = '0;
                    if (req_err) begin
                        rsp_err_d = 1'b1;
                    end else if (bus.req_op == OP_BINOM) begin
                        rsp_value_d = rd1_c;
                    end else if (bus.req_op == OP_POPCNT) begin
                        rsp_value_d = CW'(req_pop);
`ifdef PINGALA_MATRA_EN
                    end else if (bus.req_op == OP_MATRA) begin
                        if (bus.req_n == '0) begin
                            rsp_value_d = CW'(1);
                        end else begin
                            state_d     = ST_EXEC_FIB;
                            rsp_valid_d = 1'b0;
                            acc_d       = CW'(1);
                            idx_d       = '0;
                        end
`endif
                    end else if (scan_op && bus.req_n == '0) begin
                        rsp_value_d = '0;
                    end else if (bus.req_op == OP_UNRANK) begin
                        state_d     = ST_EXEC_UNRANK;
                        rsp_valid_d = 1'b0;
                        acc_d       = bus.req_index;
                    end else begin
                        state_d     = ST_EXEC_RANK;
                        rsp_valid_d = 1'b0;
                    end
                end
            end
            ST_EXEC_RANK: begin
                if (cur_bit) begin
                    sum = acc_q + rd0_c;
                    r_d = r_q - 1'b1;
                end
                acc_d = sum;
                i_d   = i_q - 1'b1;
                if (i_q == '0) begin
                    if (nxt_q) begin
                        // Successor index wraps to the lowest pattern.
                        nidx    = sum + 1'b1;
                        if (nidx == rd1_c) nidx = '0;
                        state_d = ST_EXEC_UNRANK;
                        acc_d   = nidx;
                        idx_d   = nidx;
                        i_d     = n_q - 1'b1;
                        r_d     = k_q;
                        opat_d  = '0;
                    end else begin
                        state_d       = ST_RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b0;
                        rsp_value_d   = sum;
                        rsp_pattern_d = '0;
                    end
                end
            end
            ST_EXEC_UNRANK: begin
                if (idx_q >= rd0_c) begin
                    for (int j = 0; j < N_MAX; j++) begin
                        if (NW'(j) == i_q) npat[j] = 1'b1;
                    end
                    idx_d = idx_q - rd0_c;
                    r_d   = r_q - 1'b1;
                end
                opat_d = npat;
                i_d    = i_q - 1'b1;
                if (i_q == '0) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b0;
                    rsp_value_d   = acc_q;
                    rsp_pattern_d = npat;
                end
            end
`ifdef PINGALA_MATRA_EN
            ST_EXEC_FIB: begin
                acc_d = acc_q + idx_q;
                idx_d = acc_q;
                i_d   = i_q - 1'b1;
                if (i_q == '0) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b0;
                    rsp_value_d   = acc_q + idx_q;
                    rsp_pattern_d = '0;
                end
            end
`endif
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BUILD;
            op_q          <= '0;
            n_q           <= '0;
            k_q           <= '0;
            i_q           <= '0;
            r_q           <= '0;
            pat_q         <= '0;
            opat_q        <= '0;
            idx_q         <= '0;
            acc_q         <= '0;
            nxt_q         <= 1'b0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_value_q   <= '0;
            rsp_pattern_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            n_q           <= n_d;
            k_q           <= k_d;
            i_q           <= i_d;
            r_q           <= r_d;
            pat_q         <= pat_d;
            opat_q        <= opat_d;
            idx_q         <= idx_d;
            acc_q         <= acc_d;
            nxt_q         <= nxt_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_value_q   <= rsp_value_d;
            rsp_pattern_q <= rsp_pattern_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_value   = rsp_value_q;
    assign bus.rsp_pattern = rsp_pattern_q;

endmodule

// File: tb/tb_pingala_prastara_engine.sv
// Scoreboard bench for pingala_prastara_engine: a reference model
// enumerates patterns directly and predicts every response.
module tb_pingala_prastara_engine;
    import pingala_pkg::*;

    localparam int N_MAX = 16;
    localparam int CW    = 32;
    localparam int NW    = 5;

    typedef struct {
        logic        err;
        logic [31:0] value;
        logic [15:0] pattern;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic table_ready;
    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pingala_prastara_engine_if #(.N_MAX(N_MAX), .CW(CW)) bus ();

    pingala_prastara_engine #(.N_MAX(N_MAX), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .table_ready(table_ready)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint binom(input int n, input int k);
        longint c = 1;
        if (k < 0 || k > n) return 0;
        for (int j = 0; j < k; j++) c = c * (n - j) / (j + 1);
        return c;
    endfunction

    function automatic int popc(input int n, input int p);
        int c = 0;
        for (int j = 0; j < n; j++) c += (p >> j) & 1;
        return c;
    endfunction

    function automatic int rank_of(input int n, input int k, input int p);
        int c = 0;
        for (int q = 0; q < p; q++) if (popc(n, q) == k) c++;
        return c;
    endfunction

    function automatic int unrank_of(input int n, input int k, input int idx);
        int c = 0;
        for (int q = 0; q < (1 << n); q++) begin
            if (popc(n, q) == k) begin
                if (c == idx) return q;
                c++;
            end
        end
        return 0;
    endfunction

    function automatic exp_t model(input int op, input int n, input int k,
                                   input int pat, input longint idx);
        exp_t   e;
        int     pm;
        longint b;
        int     r;
        e.err = 1'b1; e.value = '0; e.pattern = '0; e.lat = 0;
        if (n > N_MAX) return e;
        pm = pat & ((1 << n) - 1);
        b  = binom(n, k);
        case (op)
            0: begin
                if (k > n) return e;
                e.value = 32'(b);
            end
            1: e.value = 32'(popc(n, pm));
            2: begin
                if (k > n || popc(n, pm) != k) return e;
                e.value = 32'(rank_of(n, k, pm));
                e.lat   = n;
            end
            3: begin
                if (k > n || idx >= b) return e;
                e.pattern = 16'(unrank_of(n, k, int'(idx)));
                e.value   = 32'(idx);
                e.lat     = n;
            end
            4: begin
                if (k > n || popc(n, pm) != k) return e;
                r = (rank_of(n, k, pm) + 1) % int'(b);
                e.pattern = 16'(unrank_of(n, k, r));
                e.value   = 32'(r);
                e.lat     = 2 * n;
            end
`ifdef PINGALA_MATRA_EN
            5: begin
                longint a = 1, c = 0, t;
                for (int j = 0; j < n; j++) begin
                    t = a + c; c = a; a = t;
                end
                e.value = 32'(a);
                e.lat   = n;
            end
`endif
            default: return e;
        endcase
        e.err = 1'b0;
        return e;
    endfunction

    task automatic do_req(input int op, input int n, input int k,
                          input int pat, input longint idx,
                          input string tag, input int stall);
        exp_t        e;
        int          w;
        int          lat;
        logic [31:0] v0;
        logic [15:0] p0;
        sb_q.push_back(model(op, n, k, pat, idx));
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_op      = 3'(op);
        bus.req_n       = NW'(n);
        bus.req_k       = NW'(k);
        bus.req_pattern = 16'(pat);
        bus.req_index   = 32'(idx);
        w = 0;
        while (!bus.req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) begin
            check({tag, "_accept_timeout"}, 0, 1);
            bus.req_valid = 1'b0;
            void'(sb_q.pop_front());
            return;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        e = sb_q.pop_front();
        if (!bus.rsp_valid) begin
            check({tag, "_rsp_timeout"}, 0, 1);
            return;
        end
        check({tag, "_err"}, bus.rsp_err, e.err);
        check({tag, "_value"}, bus.rsp_value, e.value);
        check({tag, "_pattern"}, bus.rsp_pattern, e.pattern);
        check({tag, "_lat"}, lat, e.lat);
        v0 = bus.rsp_value;
        p0 = bus.rsp_pattern;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            check({tag, "_stall_valid"}, bus.rsp_valid, 1);
            check({tag, "_stall_value"}, bus.rsp_value, v0);
            check({tag, "_stall_pattern"}, bus.rsp_pattern, p0);
            check({tag, "_stall_req_ready"}, bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, bus.rsp_valid, 0);
        check({tag, "_req_ready_after"}, bus.req_ready, 1);
    endtask

    task automatic reset_and_build(input string tag);
        int   cyc;
        logic saw_rsp;
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rst_req_ready"}, bus.req_ready, 0);
        check({tag, "_rst_table_ready"}, table_ready, 0);
        check({tag, "_rst_value"}, bus.rsp_value, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        cyc     = 0;
        saw_rsp = 1'b0;
        while (!table_ready && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
            if (bus.rsp_valid) saw_rsp = 1'b1;
        end
        check({tag, "_build_cycles"}, cyc, N_MAX + 1);
        check({tag, "_req_ready_with_table"}, bus.req_ready, 1);
        check({tag, "_no_rsp_during_build"}, saw_rsp, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int op, n, k, p;
        longint b, ix;
        bus.req_valid   = 1'b0;
        bus.req_op      = '0;
        bus.req_n       = '0;
        bus.req_k       = '0;
        bus.req_pattern = '0;
        bus.req_index   = '0;
        bus.rsp_ready   = 1'b0;

        reset_and_build("por");

        do_req(0, 16, 8, 0, 0, "binom_16_8", 0);
        do_req(0, 5, 6, 0, 0, "binom_k_gt_n", 0);
        do_req(0, 0, 0, 0, 0, "binom_0_0", 0);
        do_req(0, 16, 16, 0, 0, "binom_16_16", 0);
        do_req(0, 17, 1, 0, 0, "binom_n_big", 0);
        do_req(1, 8, 3, 16'hF0F3, 0, "popcnt_8", 0);
        do_req(1, 16, 0, 16'hFFFF, 0, "popcnt_16", 0);
        do_req(2, 4, 2, 4'b1100, 0, "rank_1100", 0);
        do_req(2, 4, 2, 4'b0111, 0, "rank_bad_pop", 0);
        do_req(2, 4, 2, 16'hA003, 0, "rank_upper_junk", 0);
        do_req(2, 0, 0, 0, 0, "rank_n0", 0);
        do_req(3, 4, 2, 0, 5, "unrank_5", 0);
        do_req(3, 4, 2, 0, 0, "unrank_0", 0);
        do_req(3, 4, 2, 0, 6, "unrank_6", 0);
        do_req(4, 4, 2, 4'b0101, 0, "next_0101", 0);
        do_req(4, 4, 2, 4'b1100, 0, "next_wrap", 0);
        do_req(4, 16, 8, 16'hFF00, 0, "next_wrap_16", 0);
        do_req(6, 4, 2, 0, 0, "op_reserved6", 0);
        do_req(5, 10, 0, 0, 0, "matra_10", 0);
        do_req(3, 16, 8, 0, 12869, "unrank_stall", 3);

        for (int t = 0; t < 24; t++) begin
            op = $urandom_range(0, 4);
            n  = $urandom_range(0, 16);
            k  = $urandom_range(0, n);
            b  = binom(n, k);
            p  = $urandom_range(0, 16'hFFFF);
            ix = $urandom_range(0, int'(b));
            if (op == 2 || op == 4) begin
                p = unrank_of(n, k, $urandom_range(0, int'(b) - 1))
                    | (p & ~((1 << n) - 1));
            end
            do_req(op, n, k, p, ix, $sformatf("rnd%0d_op%0d", t, op), 0);
        end

        // Abort an UNRANK in flight and expect a clean rebuild.
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_op      = 3'(3);
        bus.req_n       = NW'(16);
        bus.req_k       = NW'(8);
        bus.req_index   = 32'd1000;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_no_rsp", bus.rsp_valid, 0);
        reset_and_build("abort");
        do_req(3, 4, 2, 0, 5, "post_abort_unrank", 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
